// File: rtl/gcd_pkg.sv
// Shared definitions for the parametrised GCD engine: FSM encoding,
// algorithm selectors and a constant-evaluable ceil(log2) helper.
package gcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CALC   = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    localparam int ALGO_EUCLID = 0;
    localparam int ALGO_STEIN  = 1;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/gcd_datapath.sv
// One combinational GCD iteration; ALGO picks subtractive Euclid or
// binary Stein at elaboration time.
module gcd_datapath
    import gcd_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ALGO  = 0,
    parameter int KW    = 4
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [KW-1:0]    i_k,
    output logic [WIDTH-1:0] o_a,
    output logic [WIDTH-1:0] o_b,
    output logic [KW-1:0]    o_k,
    output logic             o_eq,
    output logic [WIDTH-1:0] o_result
);

    assign o_eq = (i_a == i_b);

    generate
        if (ALGO == ALGO_STEIN) begin : g_stein
            // Shared factors of two are stripped into k and restored on the result.
            always_comb begin
                o_a = i_a;
                o_b = i_b;
                o_k = i_k;
                if (!i_a[0] && !i_b[0]) begin
                    o_a = i_a >> 1;
                    o_b = i_b >> 1;
                    o_k = i_k + 1'b1;
                end else if (!i_a[0]) begin
                    o_a = i_a >> 1;
                end else if (!i_b[0]) begin
                    o_b = i_b >> 1;
                end else if (i_a > i_b) begin
                    o_a = (i_a - i_b) >> 1;
                end else begin
                    o_b = (i_b - i_a) >> 1;
                end
            end
            assign o_result = i_a << i_k;
        end else begin : g_euclid
            always_comb begin
                o_a = i_a;
                o_b = i_b;
                o_k = i_k;
                if (i_a > i_b) begin
                    o_a = i_a - i_b;
                end else if (i_b > i_a) begin
                    o_b = i_b - i_a;
                end
            end
            assign o_result = i_a;
        end
    endgenerate

endmodule

// File: rtl/gcd_engine_param.sv
// GCD accelerator top: IDLE/CALC/FINISH control, operand registers,
// saturating iteration counter and held result registers.
module gcd_engine_param
    import gcd_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ALGO  = 0,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] Y,
    output logic             ERROR,
    output logic [CNT_W-1:0] CYCLES,
    output logic [1:0]       DBG_STATE
);

    localparam int KW = clog2(WIDTH + 1);

    // Handshake: START is level-sampled only in IDLE; BUSY covers CALC and
    // FINISH; DONE is a one-cycle Moore pulse in FINISH with Y/ERROR/CYCLES valid.
    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [KW-1:0]    r_k;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] w_a_next;
    logic [WIDTH-1:0] w_b_next;
    logic [KW-1:0]    w_k_next;
    logic             w_eq;
    logic [WIDTH-1:0] w_result;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_zero_op;

    gcd_datapath #(
        .WIDTH (WIDTH),
        .ALGO  (ALGO),
        .KW    (KW)
    ) u_datapath (
        .i_a      (r_a),
        .i_b      (r_b),
        .i_k      (r_k),
        .o_a      (w_a_next),
        .o_b      (w_b_next),
        .o_k      (w_k_next),
        .o_eq     (w_eq),
        .o_result (w_result)
    );

    assign w_zero_op = (A == '0) || (B == '0);
    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

    always_ff @(posedge CLK) begin
        if (RST) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (START) w_state_next = w_zero_op ? ST_FINISH : ST_CALC;
            ST_CALC:   if (w_eq)  w_state_next = ST_FINISH;
            ST_FINISH: w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_a    <= '0;
            r_b    <= '0;
            r_k    <= '0;
            r_cnt  <= '0;
            Y      <= '0;
            ERROR  <= 1'b0;
            CYCLES <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (START) begin
                        r_a   <= A;
                        r_b   <= B;
                        r_k   <= '0;
                        r_cnt <= '0;
                        if (w_zero_op) begin
                            Y      <= '0;
                            ERROR  <= 1'b1;
                            CYCLES <= '0;
                        end
                    end
                end
                ST_CALC: begin
                    r_cnt <= w_cnt_inc;
                    if (w_eq) begin
                        Y      <= w_result;
                        ERROR  <= 1'b0;
                        CYCLES <= w_cnt_inc;
                    end else begin
                        r_a <= w_a_next;
                        r_b <= w_b_next;
                        r_k <= w_k_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign BUSY      = (r_state != ST_IDLE);
    assign DONE      = (r_state == ST_FINISH);
    assign DBG_STATE = r_state;

endmodule
